// File: rtl/conv_kxk_tiled_accum.sv
// Tiled multi-kernel KxK convolution engine.
// Five-stage pipeline: products, per-channel sum, cross-channel sum,
// tile accumulator (IDLE/ACCUM FSM), requantised output register.
// The whole pipe stalls while an output is waiting for the downstream side.
//
// state    | meaning
// ST_IDLE  | no group open; next beat starts a new accumulation
// ST_ACCUM | group open; partial sums held in r_acc
module conv_kxk_tiled_accum #(
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_KERNELS  = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int FILTER_SIZE  = 3,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                                                                   clk,
    input  logic                                                                   rst_n,
    input  logic                                                                   i_valid,
    output logic                                                                   o_ready,
    input  logic                                                                   i_first_tile,
    input  logic                                                                   i_last_tile,
    input  logic [NUM_CHANNELS*FILTER_SIZE*FILTER_SIZE*DATA_WIDTH-1:0]             i_windows_packed,
    input  logic [NUM_KERNELS*NUM_CHANNELS*FILTER_SIZE*FILTER_SIZE*DATA_WIDTH-1:0] i_kernels_packed,
    input  logic [NUM_KERNELS*ACC_WIDTH-1:0]                                       i_bias_packed,
    input  logic [4:0]                                                             i_shift,
    input  logic                                                                   i_relu_en,
    output logic                                                                   o_valid,
    input  logic                                                                   i_out_ready,
    output logic [NUM_KERNELS*OUT_WIDTH-1:0]                                       o_data_packed,
    output logic [NUM_KERNELS-1:0]                                                 o_sat_flags,
    output logic                                                                   o_seq_err
);
    localparam int KK = FILTER_SIZE * FILTER_SIZE;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = PW + $clog2(KK) + 1;
    localparam int SW = CW + $clog2(NUM_CHANNELS) + 1;
    localparam int XW = ACC_WIDTH + 1;
    localparam logic signed [XW-1:0] OUT_MAX = XW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] OUT_MIN = XW'(-(2 ** (OUT_WIDTH - 1)));

    typedef struct packed {
        logic                             first;
        logic                             last;
        logic [NUM_KERNELS*ACC_WIDTH-1:0] bias;
        logic [4:0]                       shift;
        logic                             relu;
    } sb_t;

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    logic                         w_en;
    sb_t                          w_in_sb, r_s1_sb, r_s2_sb, r_s3_sb;
    logic                         r_s1_valid, r_s2_valid, r_s3_valid;
    logic signed [PW-1:0]         r_prod [NUM_KERNELS][NUM_CHANNELS][KK];
    logic signed [CW-1:0]         w_csum [NUM_KERNELS][NUM_CHANNELS];
    logic signed [CW-1:0]         r_csum [NUM_KERNELS][NUM_CHANNELS];
    logic signed [SW-1:0]         w_sum  [NUM_KERNELS];
    logic signed [SW-1:0]         r_sum  [NUM_KERNELS];
    state_t                       r_state, w_state_nxt;
    logic                         w_fresh, w_seq_viol;
    logic signed [XW-1:0]         w_acc_ext [NUM_KERNELS];
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt [NUM_KERNELS];
    logic [NUM_KERNELS-1:0]       w_acc_clip;
    logic signed [ACC_WIDTH-1:0]  r_acc [NUM_KERNELS];
    logic [NUM_KERNELS-1:0]       r_pend;
    logic                         r_s4_emit;
    logic [NUM_KERNELS*ACC_WIDTH-1:0] r_s4_bias;
    logic [4:0]                   r_s4_shift;
    logic                         r_s4_relu;
    logic                         r_seq_err;
    logic signed [XW-1:0]         w_bias_ext [NUM_KERNELS];
    logic signed [XW-1:0]         w_sat_v    [NUM_KERNELS];
    logic signed [XW-1:0]         w_rnd      [NUM_KERNELS];
    logic [NUM_KERNELS*OUT_WIDTH-1:0] w_out;
    logic [NUM_KERNELS-1:0]       w_out_sat;
    logic                         r_o_valid;
    logic [NUM_KERNELS*OUT_WIDTH-1:0] r_o_data;
    logic [NUM_KERNELS-1:0]       r_o_sat;

    // Clamp an ACC_WIDTH+1 sum of two ACC_WIDTH values back to ACC_WIDTH.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [XW-1:0] v);
        if (v[XW-1] != v[XW-2])
            return v[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return v[ACC_WIDTH-1:0];
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [DATA_WIDTH-1:0] a,
                                                 input logic signed [DATA_WIDTH-1:0] b);
        logic signed [PW-1:0] ax, bx;
        ax = PW'(a);
        bx = PW'(b);
        return ax * bx;
    endfunction

    assign w_en    = !(r_o_valid && !i_out_ready);
    assign o_ready = w_en;
    assign w_in_sb = '{first: i_first_tile, last: i_last_tile, bias: i_bias_packed,
                       shift: i_shift, relu: i_relu_en};

    // S1: registered element products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sb    <= '0;
            for (int n = 0; n < NUM_KERNELS; n++)
                for (int c = 0; c < NUM_CHANNELS; c++)
                    for (int k = 0; k < KK; k++) r_prod[n][c][k] <= '0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
            r_s1_sb    <= w_in_sb;
            for (int n = 0; n < NUM_KERNELS; n++)
                for (int c = 0; c < NUM_CHANNELS; c++)
                    for (int k = 0; k < KK; k++)
                        r_prod[n][c][k] <= mul(i_windows_packed[(c*KK+k)*DATA_WIDTH +: DATA_WIDTH],
                            i_kernels_packed[((n*NUM_CHANNELS+c)*KK+k)*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Per-channel KxK reduction and cross-channel reduction
    always_comb begin
        for (int n = 0; n < NUM_KERNELS; n++) begin
            w_sum[n] = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                w_csum[n][c] = '0;
                for (int k = 0; k < KK; k++) w_csum[n][c] = w_csum[n][c] + CW'(r_prod[n][c][k]);
                w_sum[n] = w_sum[n] + SW'(r_csum[n][c]);
            end
        end
    end

    // S2/S3: registered channel sums and beat sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s2_sb    <= '0;
            r_s3_sb    <= '0;
            for (int n = 0; n < NUM_KERNELS; n++) begin
                r_sum[n] <= '0;
                for (int c = 0; c < NUM_CHANNELS; c++) r_csum[n][c] <= '0;
            end
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s2_sb    <= r_s1_sb;
            r_s3_sb    <= r_s2_sb;
            for (int n = 0; n < NUM_KERNELS; n++) begin
                r_sum[n] <= w_sum[n];
                for (int c = 0; c < NUM_CHANNELS; c++) r_csum[n][c] <= w_csum[n][c];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else if (w_en) r_state <= w_state_nxt;
    end

    // FSM next state; a beat restarts the accumulator when flagged first or when no group is open
    always_comb begin
        w_state_nxt = r_state;
        w_fresh     = 1'b1;
        w_seq_viol  = 1'b0;
        if (r_s3_valid) begin
            w_fresh     = r_s3_sb.first || (r_state == ST_IDLE);
            w_seq_viol  = r_s3_sb.first ^ (r_state == ST_IDLE);
            w_state_nxt = r_s3_sb.last ? ST_IDLE : ST_ACCUM;
        end
    end

    // Saturating accumulate of the beat sum
    always_comb begin
        for (int n = 0; n < NUM_KERNELS; n++) begin
            w_acc_ext[n]  = (w_fresh ? '0 : XW'(r_acc[n])) + XW'(r_sum[n]);
            w_acc_clip[n] = w_acc_ext[n][XW-1] != w_acc_ext[n][XW-2];
            w_acc_nxt[n]  = sat_acc(w_acc_ext[n]);
        end
    end

    // S4: accumulator, pending clip bits, emit request and requant sideband
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_s4_emit  <= 1'b0;
            r_s4_bias  <= '0;
            r_s4_shift <= '0;
            r_s4_relu  <= 1'b0;
            r_seq_err  <= 1'b0;
            for (int n = 0; n < NUM_KERNELS; n++) r_acc[n] <= '0;
        end else if (w_en) begin
            r_s4_emit  <= r_s3_valid && r_s3_sb.last;
            r_s4_bias  <= r_s3_sb.bias;
            r_s4_shift <= r_s3_sb.shift;
            r_s4_relu  <= r_s3_sb.relu;
            if (w_seq_viol) r_seq_err <= 1'b1;
            if (r_s3_valid) begin
                for (int n = 0; n < NUM_KERNELS; n++) begin
                    r_acc[n]  <= w_acc_nxt[n];
                    r_pend[n] <= (w_fresh ? 1'b0 : r_pend[n]) | w_acc_clip[n];
                end
            end
        end
    end

    // Requantisation: bias, round-half-up shift, ReLU, clamp to OUT_WIDTH
    always_comb begin
        for (int n = 0; n < NUM_KERNELS; n++) begin
            w_bias_ext[n] = XW'(r_acc[n]) + XW'($signed(r_s4_bias[n*ACC_WIDTH +: ACC_WIDTH]));
            w_sat_v[n]    = XW'(sat_acc(w_bias_ext[n]));
            w_rnd[n]      = w_sat_v[n];
            w_out_sat[n]  = r_pend[n] | (w_bias_ext[n][XW-1] != w_bias_ext[n][XW-2]);
            if (r_s4_shift != 5'd0) begin
                if (int'(r_s4_shift) >= ACC_WIDTH)
                    w_rnd[n] = w_sat_v[n][XW-1] ? '1 : '0;
                else
                    w_rnd[n] = (w_sat_v[n] + (XW'(1) << (r_s4_shift - 5'd1))) >>> r_s4_shift;
            end
            if (r_s4_relu && w_rnd[n][XW-1]) w_rnd[n] = '0;
            if (w_rnd[n] > OUT_MAX) begin
                w_out[n*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
                w_out_sat[n] = 1'b1;
            end else if (w_rnd[n] < OUT_MIN) begin
                w_out[n*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
                w_out_sat[n] = 1'b1;
            end else begin
                w_out[n*OUT_WIDTH +: OUT_WIDTH] = w_rnd[n][OUT_WIDTH-1:0];
            end
        end
    end

    // S5: output register, held while downstream is not ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_sat   <= '0;
        end else if (w_en) begin
            r_o_valid <= r_s4_emit;
            if (r_s4_emit) begin
                r_o_data <= w_out;
                r_o_sat  <= w_out_sat;
            end
        end
    end

    assign o_valid       = r_o_valid;
    assign o_data_packed = r_o_data;
    assign o_sat_flags   = r_o_sat;
    assign o_seq_err     = r_seq_err;
endmodule

// File: tb/tb_conv_kxk_tiled_accum.sv
// Bench for conv_kxk_tiled_accum: directed steps with a behavioural model
// that pushes expected group results, popped as outputs are handed off.
`timescale 1ns/1ps
module tb_conv_kxk_tiled_accum;
    localparam int NC = 2;
    localparam int NK = 2;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int KK = K * K;
    localparam int WW = NC * KK * DW;
    localparam int KW = NK * NC * KK * DW;
    localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic             i_first_tile = 1'b0;
    logic             i_last_tile = 1'b0;
    logic [WW-1:0]    i_windows_packed = '0;
    logic [KW-1:0]    i_kernels_packed = '0;
    logic [NK*AW-1:0] i_bias_packed = '0;
    logic [4:0]       i_shift = '0;
    logic             i_relu_en = 1'b0;
    logic             o_valid;
    logic             i_out_ready = 1'b1;
    logic [NK*OW-1:0] o_data_packed;
    logic [NK-1:0]    o_sat_flags;
    logic             o_seq_err;

    conv_kxk_tiled_accum #(
        .NUM_CHANNELS(NC), .NUM_KERNELS(NK), .DATA_WIDTH(DW),
        .FILTER_SIZE(K), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_first_tile(i_first_tile), .i_last_tile(i_last_tile),
        .i_windows_packed(i_windows_packed), .i_kernels_packed(i_kernels_packed),
        .i_bias_packed(i_bias_packed), .i_shift(i_shift), .i_relu_en(i_relu_en),
        .o_valid(o_valid), .i_out_ready(i_out_ready), .o_data_packed(o_data_packed),
        .o_sat_flags(o_sat_flags), .o_seq_err(o_seq_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct packed {
        logic [NK*OW-1:0] data;
        logic [NK-1:0]    sat;
    } exp_t;
    exp_t sbq[$];

    longint  m_acc [NK];
    bit [NK-1:0] m_pend;
    bit      m_in_group;
    bit      m_seq_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [WW-1:0] fill_win(input int v);
        logic [WW-1:0] r;
        for (int i = 0; i < NC * KK; i++) r[i*DW +: DW] = v[DW-1:0];
        return r;
    endfunction

    function automatic logic [KW-1:0] fill_ker(input int v);
        logic [KW-1:0] r;
        for (int i = 0; i < NK * NC * KK; i++) r[i*DW +: DW] = v[DW-1:0];
        return r;
    endfunction

    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] r;
        for (int i = 0; i < NC * KK; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [KW-1:0] rand_ker();
        logic [KW-1:0] r;
        for (int i = 0; i < NK * NC * KK; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Model of one accepted beat; pushes the expected result on a last tile.
    task automatic model_beat(input bit f, input bit l);
        longint s, t, v;
        bit     ef;
        exp_t   e;
        ef = f || !m_in_group;
        if ((f && m_in_group) || (!f && !m_in_group)) m_seq_err = 1'b1;
        for (int n = 0; n < NK; n++) begin
            s = 0;
            for (int c = 0; c < NC; c++)
                for (int k = 0; k < KK; k++)
                    s += longint'($signed(i_windows_packed[(c*KK+k)*DW +: DW])) *
                         longint'($signed(i_kernels_packed[((n*NC+c)*KK+k)*DW +: DW]));
            t = (ef ? 0 : m_acc[n]) + s;
            if (ef) m_pend[n] = 1'b0;
            if (t > ACC_MAX) begin t = ACC_MAX; m_pend[n] = 1'b1; end
            else if (t < ACC_MIN) begin t = ACC_MIN; m_pend[n] = 1'b1; end
            m_acc[n] = t;
        end
        if (l) begin
            for (int n = 0; n < NK; n++) begin
                e.sat[n] = m_pend[n];
                v = m_acc[n] + longint'($signed(i_bias_packed[n*AW +: AW]));
                if (v > ACC_MAX) begin v = ACC_MAX; e.sat[n] = 1'b1; end
                else if (v < ACC_MIN) begin v = ACC_MIN; e.sat[n] = 1'b1; end
                if (i_shift != 5'd0) v = (v + (longint'(1) << (int'(i_shift) - 1))) >>> i_shift;
                if (i_relu_en && v < 0) v = 0;
                if (v > 127) begin v = 127; e.sat[n] = 1'b1; end
                else if (v < -128) begin v = -128; e.sat[n] = 1'b1; end
                e.data[n*OW +: OW] = v[OW-1:0];
            end
            sbq.push_back(e);
            m_in_group = 1'b0;
        end else begin
            m_in_group = 1'b1;
        end
    endtask

    // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input bit f, input bit l, input logic [WW-1:0] win, input logic [KW-1:0] ker,
                        input int bias_v, input int sh, input bit relu);
        int guard;
        i_valid          = 1'b1;
        i_first_tile     = f;
        i_last_tile      = l;
        i_windows_packed = win;
        i_kernels_packed = ker;
        i_bias_packed    = {NK{bias_v[AW-1:0]}};
        i_shift          = sh[4:0];
        i_relu_en        = relu;
        guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) begin
            chk("accept_timeout", {63'd0, o_ready}, 64'd1);
            i_valid = 1'b0;
            return;
        end
        model_beat(f, l);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || o_valid) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_queue", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sbq.delete();
        m_in_group = 1'b0;
        m_seq_err  = 1'b0;
        m_pend     = '0;
        for (int n = 0; n < NK; n++) m_acc[n] = 0;
        @(negedge clk);
        chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_o_data", 64'(o_data_packed), 64'd0);
        chk("rst_o_sat", 64'(o_sat_flags), 64'd0);
        chk("rst_o_seq_err", {63'd0, o_seq_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Output side of the scoreboard: compare on every handshake.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_out_ready) begin
            chk("out_has_expected", {63'd0, sbq.size() != 0}, 64'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", 64'(o_data_packed), 64'(e.data));
                chk("out_sat", 64'(o_sat_flags), 64'(e.sat));
            end
        end
    end

    initial begin
        int lat;
        logic [NK*OW-1:0] held;
        for (int n = 0; n < NK; n++) m_acc[n] = 0;
        m_pend = '0;
        m_in_group = 1'b0;
        m_seq_err = 1'b0;

        // Reset state
        do_reset();
        @(posedge clk);
        #1;

        // Single-tile group with latency measurement
        send(1, 1, fill_win(1), fill_ker(1), 0, 0, 0);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_valid) break;
        end
        chk("t1_latency", 64'(lat), 64'd5);
        chk("t1_data", 64'(o_data_packed), 64'h1212);
        chk("t1_sat", 64'(o_sat_flags), 64'd0);
        drain();

        // Three tiles, unshifted then shifted by 2
        send(1, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 1, fill_win(1), fill_ker(1), 0, 0, 0);
        send(1, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 1, fill_win(1), fill_ker(1), 0, 2, 0);
        drain();

        // Negative bias with and without ReLU; bias on non-last beats is ignored
        send(1, 0, fill_win(1), fill_ker(1), 1000, 7, 1);
        send(0, 0, fill_win(1), fill_ker(1), 1000, 7, 1);
        send(0, 1, fill_win(1), fill_ker(1), -60, 0, 0);
        send(1, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 1, fill_win(1), fill_ker(1), -60, 0, 1);
        drain();

        // Output clipping, positive and negative
        send(1, 1, fill_win(127), fill_ker(127), 0, 0, 0);
        send(1, 1, fill_win(-128), fill_ker(127), 0, 0, 0);
        drain();
        // Bias saturation of the accumulator followed by a large shift
        send(1, 1, fill_win(127), fill_ker(127), 2147483000, 24, 0);
        // Random groups
        for (int g = 0; g < 3; g++) begin
            send(1, 0, rand_win(), rand_ker(), 0, 0, 0);
            send(0, 1, rand_win(), rand_ker(), int'($urandom_range(0, 2000)) - 1000,
                 int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));
        end
        drain();

        // Downstream stall: o_ready low, held output stable, no loss, order kept
        i_out_ready = 1'b0;
        send(1, 1, fill_win(1), fill_ker(1), 0, 0, 0);
        send(1, 1, fill_win(2), fill_ker(1), 0, 0, 0);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_valid_seen", {63'd0, o_valid}, 64'd1);
        held = o_data_packed;
        fork
            send(1, 1, fill_win(3), fill_ker(1), 0, 0, 0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("t5_o_ready_low", {63'd0, o_ready}, 64'd0);
                    chk("t5_o_valid_held", {63'd0, o_valid}, 64'd1);
                    chk("t5_data_stable", 64'(o_data_packed), 64'(held));
                end
                @(posedge clk);
                #1;
                i_out_ready = 1'b1;
            end
        join
        drain();

        // Sequence errors: mid beat without first, then first while a group is open
        send(0, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 1, fill_win(1), fill_ker(1), 0, 0, 0);
        drain();
        chk("t6_seq_err", {63'd0, o_seq_err}, {63'd0, m_seq_err});
        send(1, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(1, 1, fill_win(2), fill_ker(1), 0, 0, 0);
        drain();
        chk("t6_seq_err_sticky", {63'd0, o_seq_err}, {63'd0, m_seq_err});

        // Reset in the middle of a group, then a clean group
        send(1, 0, fill_win(5), fill_ker(1), 0, 0, 0);
        do_reset();
        send(1, 0, fill_win(1), fill_ker(1), 0, 0, 0);
        send(0, 1, fill_win(1), fill_ker(2), 0, 0, 0);
        drain();
        chk("final_seq_err", {63'd0, o_seq_err}, {63'd0, m_seq_err});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
